// File: rtl/lvds_bit_align.sv
// lvds_bit_align: per-lane delay-tap scanner that centres the sampling point
// in the widest stable data eye before the downstream bitslip search starts.
// Optional feature macro: LVDS_BIT_ALIGN_RETRY_EN (up to 3 automatic re-sweeps
// before align_error is raised).
module lvds_bit_align #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned TAP_WIDTH     = 5,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_EYE       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  align_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  delay_ld,
  output logic [TAP_WIDTH-1:0]  delay_tap,
  output logic                  bit_align_done,
  output logic                  align_error
);

  // Run lengths need one extra bit so a full-range eye (2^TAP_WIDTH) fits.
  localparam int unsigned LEN_W   = TAP_WIDTH + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_CENTER,
    S_CSETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                r_state;
  logic [TAP_WIDTH-1:0]  r_tap;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_ref;
  logic                  r_stable;
  logic [LEN_W-1:0]      r_run_len;
  logic [TAP_WIDTH-1:0]  r_run_start;
  logic [LEN_W-1:0]      r_best_len;
  logic [TAP_WIDTH-1:0]  r_best_start;
  logic                  r_delay_ld;
  logic [TAP_WIDTH-1:0]  r_delay_tap;
  logic                  r_done;
  logic                  r_error;
`ifdef LVDS_BIT_ALIGN_RETRY_EN
  logic [2:0]            r_retry;
`endif

  logic [LEN_W-1:0]      w_run_len;
  logic [TAP_WIDTH-1:0]  w_run_start;
  logic                  w_best_upd;
  logic [LEN_W-1:0]      w_best_len;
  logic [TAP_WIDTH-1:0]  w_best_start;
  logic [LEN_W-1:0]      w_center_full;
  logic [TAP_WIDTH-1:0]  w_center;
  logic                  w_eye_ok;
  logic [TAP_WIDTH-1:0]  w_tap_next;
  logic                  w_tap_max;
  logic                  w_settle_last;
  logic                  w_sample_last;

  // Run/best bookkeeping for the tap being evaluated; the centre tap is
  // derived from the post-update best so it can be loaded on CENTER entry.
  assign w_run_len     = r_stable ? (r_run_len + LEN_W'(1)) : LEN_W'(0);
  assign w_run_start   = (r_stable && (r_run_len == LEN_W'(0))) ? r_tap : r_run_start;
  assign w_best_upd    = (w_run_len > r_best_len);
  assign w_best_len    = w_best_upd ? w_run_len   : r_best_len;
  assign w_best_start  = w_best_upd ? w_run_start : r_best_start;
  assign w_center_full = {1'b0, w_best_start} + ((w_best_len - LEN_W'(1)) >> 1);
  assign w_center      = TAP_WIDTH'(w_center_full);
  assign w_eye_ok      = (w_best_len >= LEN_W'(MIN_EYE));
  assign w_tap_next    = r_tap + TAP_WIDTH'(1);
  assign w_tap_max     = (r_tap == {TAP_WIDTH{1'b1}});
  assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_sample_last = (r_cnt == CNT_W'(SAMPLE_CYCLES - 1));

  // Sweep controller: one state register with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_cnt        <= '0;
      r_ref        <= '0;
      r_stable     <= 1'b0;
      r_run_len    <= '0;
      r_run_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
      r_delay_ld   <= 1'b0;
      r_delay_tap  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LVDS_BIT_ALIGN_RETRY_EN
      r_retry      <= '0;
`endif
    end else begin
      r_delay_ld <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (align_start) begin
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_tap        <= '0;
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_delay_ld   <= 1'b1;
            r_delay_tap  <= '0;
`ifdef LVDS_BIT_ALIGN_RETRY_EN
            r_retry      <= '0;
`endif
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (w_settle_last) begin
            r_cnt   <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (r_cnt == CNT_W'(0)) begin
            r_ref    <= data_in;
            r_stable <= 1'b1;
          end else if (data_in != r_ref) begin
            r_stable <= 1'b0;
          end
          if (w_sample_last) begin
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EVAL: begin
          r_run_len    <= w_run_len;
          r_run_start  <= w_run_start;
          r_best_len   <= w_best_len;
          r_best_start <= w_best_start;
          if (w_tap_max) begin
            r_state <= S_CENTER;
            if (w_eye_ok) begin
              r_delay_ld  <= 1'b1;
              r_delay_tap <= w_center;
            end
          end else begin
            r_tap       <= w_tap_next;
            r_delay_ld  <= 1'b1;
            r_delay_tap <= w_tap_next;
            r_state     <= S_LOAD;
          end
        end
        S_CENTER: begin
          r_cnt <= '0;
          if (r_best_len >= LEN_W'(MIN_EYE)) begin
            r_state <= S_CSETTLE;
          end else begin
`ifdef LVDS_BIT_ALIGN_RETRY_EN
            if (r_retry < 3'd3) begin
              r_retry      <= r_retry + 3'd1;
              r_tap        <= '0;
              r_run_len    <= '0;
              r_run_start  <= '0;
              r_best_len   <= '0;
              r_best_start <= '0;
              r_delay_ld   <= 1'b1;
              r_delay_tap  <= '0;
              r_state      <= S_LOAD;
            end else begin
              r_error <= 1'b1;
              r_state <= S_FAIL;
            end
`else
            r_error <= 1'b1;
            r_state <= S_FAIL;
`endif
          end
        end
        S_CSETTLE: begin
          if (w_settle_last) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign delay_ld       = r_delay_ld;
  assign delay_tap      = r_delay_tap;
  assign bit_align_done = r_done;
  assign align_error    = r_error;

endmodule

// File: tb/tb_lvds_bit_align.sv
// Directed bench for lvds_bit_align: a tap-dependent data source models the
// delay line, a table of eye patterns drives full sweeps, and hand-written
// sequences cover reset behaviour and a mid-sweep reset.
module tb_lvds_bit_align;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       align_start = 1'b1;
  logic [9:0] data_in = '0;
  logic       delay_ld;
  logic [4:0] delay_tap;
  logic       bit_align_done;
  logic       align_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cur_mask = '0;
  logic [4:0]  cur_tap  = '0;

  typedef struct {
    logic [31:0] mask;
    bit          exp_done;
    logic [4:0]  exp_tap;
    int          exp_lds;
    int          exp_lat;
    bit          pulses;
  } vec_t;

  vec_t vecs[7];

  lvds_bit_align dut (
    .clk            (clk),
    .rst            (rst),
    .align_start    (align_start),
    .data_in        (data_in),
    .delay_ld       (delay_ld),
    .delay_tap      (delay_tap),
    .bit_align_done (bit_align_done),
    .align_error    (align_error)
  );

  initial forever #5 clk = ~clk;

  // Delay-line model: the tap latched on a load decides whether the lane
  // sees the steady training word or noise.
  initial forever begin
    @(negedge clk);
    if (delay_ld === 1'b1) cur_tap = delay_tap;
    data_in = cur_mask[cur_tap] ? 10'h3A5 : 10'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int         lds = 0;
    int         lat = 0;
    logic [4:0] last_tap = '0;
    logic [4:0] prev_tap;
    bit         glitch = 1'b0;
    bit         first_ok = 1'b0;
    @(negedge clk);
    cur_mask    = v.mask;
    align_start = 1'b1;
    prev_tap    = delay_tap;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      align_start = v.pulses && (n < 700) && (((n - 1) % 22) == 10);
      if (n == 1)
        first_ok = (delay_ld === 1'b1) && (delay_tap === 5'd0) &&
                   (bit_align_done === 1'b0) && (align_error === 1'b0);
      if (delay_ld === 1'b1) begin
        lds++;
        last_tap = delay_tap;
      end else if (delay_tap !== prev_tap) begin
        glitch = 1'b1;
      end
      prev_tap = delay_tap;
      if (bit_align_done === 1'b1 || align_error === 1'b1) begin
        lat = n;
        break;
      end
    end
    align_start = 1'b0;
    chk($sformatf("c%0d_first_load_flags_clear", idx), 32'(first_ok), 32'd1);
    chk($sformatf("c%0d_outcome", idx), {30'd0, bit_align_done, align_error},
        v.exp_done ? 32'd2 : 32'd1);
    chk($sformatf("c%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("c%0d_ld_pulses", idx), 32'(lds), 32'(v.exp_lds));
    chk($sformatf("c%0d_last_tap", idx), 32'(last_tap), 32'(v.exp_tap));
    chk($sformatf("c%0d_tap_only_on_ld", idx), 32'(glitch), 32'd0);
    repeat (5) @(negedge clk);
    chk($sformatf("c%0d_held", idx),
        {24'd0, delay_ld, bit_align_done, align_error, delay_tap},
        {24'd0, 1'b0, v.exp_done, !v.exp_done, v.exp_tap});
  endtask

  initial begin
    // Eye patterns and expected centres, computed by hand.
    vecs[0] = '{32'h0003_FC00, 1'b1, 5'd13, 33, 710, 1'b0};  // eye 10..17
    vecs[1] = '{32'h03F0_01F8, 1'b1, 5'd5,  33, 710, 1'b0};  // tie, earliest wins
    vecs[2] = '{32'hF000_0000, 1'b1, 5'd29, 33, 710, 1'b0};  // eye ends at max tap
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 5'd15, 33, 710, 1'b0};  // full-range eye
`ifdef LVDS_BIT_ALIGN_RETRY_EN
    vecs[4] = '{32'h0000_00E0, 1'b0, 5'd31, 128, 2821, 1'b0}; // short eye, 4 sweeps
`else
    vecs[4] = '{32'h0000_00E0, 1'b0, 5'd31, 32, 706, 1'b0};   // short eye, fail
`endif
    vecs[5] = '{32'h0003_FC00, 1'b1, 5'd13, 33, 710, 1'b1};  // from FAIL, noisy start
    vecs[6] = '{32'hF000_000F, 1'b1, 5'd1,  33, 710, 1'b0};  // tie at both ends

    // Reset held with align_start high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_cycle%0d", i),
          {24'd0, delay_ld, bit_align_done, align_error, delay_tap}, 32'd0);
    end
    rst = 1'b0;
    align_start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {24'd0, delay_ld, bit_align_done, align_error, delay_tap}, 32'd0);

    for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

    // Mid-sweep reset at tap 12: IDLE on the next cycle, no stray load.
    begin
      bit found = 1'b0;
      bit any_ld = 1'b0;
      @(negedge clk);
      cur_mask    = 32'h0003_FC00;
      align_start = 1'b1;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        align_start = 1'b0;
        if (delay_ld === 1'b1 && delay_tap === 5'd12) begin
          found = 1'b1;
          rst = 1'b1;
          break;
        end
      end
      chk("midsweep_reached_tap12", 32'(found), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      chk("midsweep_reset_outputs",
          {24'd0, delay_ld, bit_align_done, align_error, delay_tap}, 32'd0);
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (delay_ld !== 1'b0) any_ld = 1'b1;
      end
      chk("midsweep_stays_idle", 32'(any_ld), 32'd0);
    end
    run_case(7, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
